// File: rtl/board_reveal_engine_if.sv
// Command/status-RAM bundle between the game front end and the 5x5 board reveal engine.
interface board_reveal_engine_if;
    logic [24:0] mine_map;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_x;
    logic [2:0]  cmd_y;
    logic        cmd_ready;
    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic        busy;
    logic        game_over;
    logic        game_won;

    modport master (
        output mine_map, cmd_valid, cmd_op, cmd_x, cmd_y,
        input  cmd_ready, wEn, addr, dataIn, busy, game_over, game_won
    );

    modport slave (
        input  mine_map, cmd_valid, cmd_op, cmd_x, cmd_y,
        output cmd_ready, wEn, addr, dataIn, busy, game_over, game_won
    );
endinterface

// File: rtl/board_reveal_engine.sv
// 5x5 minesweeper game engine: turns cursor commands into one status-RAM write per cycle,
// flood-filling zero-count regions and tracking win/loss.
module board_reveal_engine (
    input  logic                  clk,
    input  logic                  reset,
    board_reveal_engine_if.slave  bus
);
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_REVEAL, S_LOSE} state_t;

    localparam logic [3:0] ST_MINE   = 4'd9;
    localparam logic [3:0] ST_HIDDEN = 4'd10;
    localparam logic [3:0] ST_FLAG   = 4'd11;
    localparam logic [4:0] IDX_DONE  = 5'd25;

    function automatic logic [24:0] neighbors(input int c);
        logic [24:0] m;
        int cx, cy, nx, ny;
        m  = '0;
        cx = c % 5;
        cy = c / 5;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = cx + dx;
                ny = cy + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < 5 && ny >= 0 && ny < 5)
                    m[ny * 5 + nx] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [3:0] popcnt4(input logic [24:0] v);
        logic [3:0] acc;
        acc = '0;
        for (int i = 0; i < 25; i++) acc = acc + 4'(v[i]);
        return acc;
    endfunction

    function automatic logic [4:0] popcnt5(input logic [24:0] v);
        logic [4:0] acc;
        acc = '0;
        for (int i = 0; i < 25; i++) acc = acc + 5'(v[i]);
        return acc;
    endfunction

    state_t      state_reg;
    logic [4:0]  idx_reg;
    logic [3:0]  shadow_reg [25];
    logic [24:0] mine_reg;
    logic [24:0] pend_reg;
    logic [4:0]  revealed_reg;
    logic        over_reg;
    logic        won_reg;
    logic        wen_reg;
    logic [4:0]  addr_reg;
    logic [3:0]  data_reg;
    logic        ready_reg;

    logic [24:0] nbr_all   [25];
    logic [3:0]  count_all [25];
    logic [24:0] hidden_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_cell
            assign nbr_all[gi]    = neighbors(gi);
            assign count_all[gi]  = popcnt4(nbr_all[gi] & mine_reg);
            assign hidden_vec[gi] = (shadow_reg[gi] == ST_HIDDEN);
        end
    endgenerate

    logic [4:0]  tgt_idx;
    logic        tgt_in_range;
    logic [3:0]  tgt_status;
    logic [4:0]  low_idx;
    logic [4:0]  cur_cell;
    logic [3:0]  cur_count;
    logic [24:0] next_pend;
    logic [4:0]  mine_pop;
    logic        won_hit;

    assign tgt_idx      = {2'b0, bus.cmd_y} * 5'd5 + {2'b0, bus.cmd_x};
    assign tgt_in_range = (bus.cmd_x < 3'd5) && (bus.cmd_y < 3'd5);
    assign tgt_status   = shadow_reg[tgt_idx];

    always_comb begin
        low_idx = 5'd0;
        for (int i = 24; i >= 0; i--) begin
            if (pend_reg[i]) low_idx = 5'(i);
        end
    end

    // The first flood cell is the cursor target itself, processed at the acceptance edge.
    always_comb begin
        cur_cell  = (state_reg == S_REVEAL) ? low_idx : tgt_idx;
        cur_count = count_all[cur_cell];
        next_pend = ((state_reg == S_REVEAL) ? pend_reg : 25'd0) & ~(25'd1 << cur_cell);
        if (cur_count == 4'd0)
            next_pend = next_pend | (nbr_all[cur_cell] & hidden_vec & ~mine_reg);
    end

    assign mine_pop = popcnt5(mine_reg);
    assign won_hit  = ({1'b0, revealed_reg} == (6'd25 - {1'b0, mine_pop}));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= S_CLEAR;
            idx_reg      <= 5'd0;
            mine_reg     <= bus.mine_map;
            pend_reg     <= '0;
            revealed_reg <= '0;
            over_reg     <= 1'b0;
            won_reg      <= 1'b0;
            wen_reg      <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            ready_reg    <= 1'b0;
        end else begin
            wen_reg <= 1'b0;
            case (state_reg)
                S_CLEAR: begin
                    if (idx_reg == IDX_DONE) begin
                        state_reg <= S_IDLE;
                        ready_reg <= 1'b1;
                    end else begin
                        wen_reg              <= 1'b1;
                        addr_reg             <= idx_reg;
                        data_reg             <= ST_HIDDEN;
                        shadow_reg[idx_reg]  <= ST_HIDDEN;
                        idx_reg              <= idx_reg + 5'd1;
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_op == 2'd2) begin
                            // Cell 0 is written at the acceptance edge; the scan continues from 1.
                            mine_reg      <= bus.mine_map;
                            over_reg      <= 1'b0;
                            won_reg       <= 1'b0;
                            revealed_reg  <= '0;
                            pend_reg      <= '0;
                            wen_reg       <= 1'b1;
                            addr_reg      <= 5'd0;
                            data_reg      <= ST_HIDDEN;
                            shadow_reg[0] <= ST_HIDDEN;
                            idx_reg       <= 5'd1;
                            state_reg     <= S_CLEAR;
                            ready_reg     <= 1'b0;
                        end else if (!over_reg && !won_reg && tgt_in_range) begin
                            if (bus.cmd_op == 2'd0 && tgt_status == ST_HIDDEN) begin
                                wen_reg   <= 1'b1;
                                addr_reg  <= tgt_idx;
                                ready_reg <= 1'b0;
                                if (mine_reg[tgt_idx]) begin
                                    data_reg            <= ST_MINE;
                                    shadow_reg[tgt_idx] <= ST_MINE;
                                    idx_reg             <= 5'd0;
                                    state_reg           <= S_LOSE;
                                end else begin
                                    data_reg             <= cur_count;
                                    shadow_reg[cur_cell] <= cur_count;
                                    pend_reg             <= next_pend;
                                    revealed_reg         <= revealed_reg + 5'd1;
                                    state_reg            <= S_REVEAL;
                                end
                            end else if (bus.cmd_op == 2'd1 &&
                                         (tgt_status == ST_HIDDEN || tgt_status == ST_FLAG)) begin
                                wen_reg             <= 1'b1;
                                addr_reg            <= tgt_idx;
                                data_reg            <= (tgt_status == ST_HIDDEN) ? ST_FLAG : ST_HIDDEN;
                                shadow_reg[tgt_idx] <= (tgt_status == ST_HIDDEN) ? ST_FLAG : ST_HIDDEN;
                            end
                        end
                    end
                end
                S_REVEAL: begin
                    if (pend_reg == 25'd0) begin
                        state_reg <= S_IDLE;
                        ready_reg <= 1'b1;
                        if (won_hit) won_reg <= 1'b1;
                    end else begin
                        wen_reg              <= 1'b1;
                        addr_reg             <= cur_cell;
                        data_reg             <= cur_count;
                        shadow_reg[cur_cell] <= cur_count;
                        pend_reg             <= next_pend;
                        revealed_reg         <= revealed_reg + 5'd1;
                    end
                end
                S_LOSE: begin
                    if (idx_reg == IDX_DONE) begin
                        over_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                        ready_reg <= 1'b1;
                    end else begin
                        wen_reg  <= mine_reg[idx_reg];
                        addr_reg <= idx_reg;
                        data_reg <= ST_MINE;
                        if (mine_reg[idx_reg]) shadow_reg[idx_reg] <= ST_MINE;
                        idx_reg  <= idx_reg + 5'd1;
                    end
                end
                default: state_reg <= S_CLEAR;
            endcase
        end
    end

    assign bus.cmd_ready = ready_reg;
    assign bus.busy      = ~ready_reg;
    assign bus.wEn       = wen_reg;
    assign bus.addr      = {7'b0, addr_reg};
    assign bus.dataIn    = {28'b0, data_reg};
    assign bus.game_over = over_reg;
    assign bus.game_won  = won_reg;
endmodule

// File: tb/tb_board_reveal_engine.sv
// Self-checking bench for board_reveal_engine: directed table, reset/abort sequences and
// randomized commands scored against a cell-level game model.
module tb_board_reveal_engine;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    board_reveal_engine_if bus();
    board_reveal_engine dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int a; int d; } wr_t;
    wr_t exp_q[$];
    int  exp_busy;

    int        st [25];
    bit [24:0] m_mines;
    bit        m_over, m_won;

    typedef struct {
        logic [1:0]  op;
        int          x;
        int          y;
        logic [24:0] map;
        int          nw;
        int          busy;
        bit          over;
        bit          won;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int count_adj(input int c);
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                int nx = c % 5 + dx;
                int ny = c / 5 + dy;
                if ((dx != 0 || dy != 0) && nx >= 0 && nx < 5 && ny >= 0 && ny < 5)
                    n += int'(m_mines[ny * 5 + nx]);
            end
        return n;
    endfunction

    task automatic model_clear(input logic [24:0] map);
        exp_q.delete();
        m_mines = map;
        m_over = 0;
        m_won = 0;
        for (int i = 0; i < 25; i++) begin
            st[i] = 10;
            exp_q.push_back('{i, 10});
        end
        exp_busy = 25;
    endtask

    task automatic model_cmd(input logic [1:0] op, input int x, input int y, input logic [24:0] map);
        int c;
        bit pend [25];
        exp_q.delete();
        exp_busy = 0;
        if (op == 2'd3) return;
        if (op == 2'd2) begin
            model_clear(map);
            return;
        end
        if (m_over || m_won || x > 4 || y > 4) return;
        c = 5 * y + x;
        if (op == 2'd1) begin
            if (st[c] == 10) begin st[c] = 11; exp_q.push_back('{c, 11}); end
            else if (st[c] == 11) begin st[c] = 10; exp_q.push_back('{c, 10}); end
            return;
        end
        if (st[c] != 10) return;
        if (m_mines[c]) begin
            st[c] = 9;
            exp_q.push_back('{c, 9});
            for (int i = 0; i < 25; i++)
                if (m_mines[i]) begin st[i] = 9; exp_q.push_back('{i, 9}); end
            exp_busy = 26;
            m_over = 1;
            return;
        end
        foreach (pend[i]) pend[i] = 0;
        pend[c] = 1;
        forever begin
            int lo = -1;
            int n;
            for (int i = 0; i < 25; i++) if (pend[i] && lo < 0) lo = i;
            if (lo < 0) break;
            n = count_adj(lo);
            st[lo] = n;
            pend[lo] = 0;
            exp_q.push_back('{lo, n});
            if (n == 0)
                for (int j = 0; j < 25; j++) begin
                    int ddx = j % 5 - lo % 5;
                    int ddy = j / 5 - lo / 5;
                    if (j != lo && ddx >= -1 && ddx <= 1 && ddy >= -1 && ddy <= 1 &&
                        st[j] == 10 && !m_mines[j])
                        pend[j] = 1;
                end
        end
        exp_busy = exp_q.size();
        begin
            int rev = 0;
            int safe = 25;
            for (int i = 0; i < 25; i++) begin
                if (st[i] <= 8) rev++;
                if (m_mines[i]) safe--;
            end
            m_won = (rev == safe);
        end
    endtask

    // Called at a negedge right after the stimulus is set up; ends at the negedge where cmd_ready is high.
    task automatic observe(output int nw, output int bz);
        int seq_err = 0;
        int cons_err = 0;
        int cyc = 0;
        nw = 0;
        bz = 0;
        forever begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            cyc++;
            if (bus.busy != !bus.cmd_ready) cons_err++;
            if (bus.wEn) begin
                if (nw >= exp_q.size() || int'(bus.addr) != exp_q[nw].a ||
                    int'(bus.dataIn) != exp_q[nw].d)
                    seq_err++;
                nw++;
            end
            if (bus.cmd_ready) break;
            bz++;
            if (cyc > 200) begin
                check("ready_timeout", cyc, 0);
                break;
            end
        end
        if (nw != exp_q.size()) seq_err++;
        check("write_sequence", seq_err, 0);
        check("busy_vs_ready", cons_err, 0);
    endtask

    task automatic issue(input logic [1:0] op, input int x, input int y, input logic [24:0] map,
                         output int nw, output int bz);
        model_cmd(op, x, y, map);
        bus.mine_map  = map;
        bus.cmd_op    = op;
        bus.cmd_x     = 3'(x);
        bus.cmd_y     = 3'(y);
        bus.cmd_valid = 1'b1;
        observe(nw, bz);
        check("busy_cycles", bz, exp_busy);
        check("game_over", int'(bus.game_over), int'(m_over));
        check("game_won", int'(bus.game_won), int'(m_won));
        $display("[TB] cmd op=%0d x=%0d y=%0d writes=%0d busy=%0d over=%0d won=%0d",
                 op, x, y, nw, bz, bus.game_over, bus.game_won);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [21];
        int nw, bz;

        vt[0]  = '{2'd0, 4, 4, 25'h1,    24, 24, 1'b0, 1'b1};
        vt[1]  = '{2'd0, 0, 0, 25'h1,     0,  0, 1'b0, 1'b1};
        vt[2]  = '{2'd2, 0, 0, 25'h1001, 25, 25, 1'b0, 1'b0};
        vt[3]  = '{2'd1, 2, 2, 25'h1001,  1,  0, 1'b0, 1'b0};
        vt[4]  = '{2'd0, 2, 2, 25'h1001,  0,  0, 1'b0, 1'b0};
        vt[5]  = '{2'd1, 2, 2, 25'h1001,  1,  0, 1'b0, 1'b0};
        vt[6]  = '{2'd0, 7, 1, 25'h1001,  0,  0, 1'b0, 1'b0};
        vt[7]  = '{2'd3, 0, 0, 25'h1001,  0,  0, 1'b0, 1'b0};
        vt[8]  = '{2'd1, 5, 0, 25'h1001,  0,  0, 1'b0, 1'b0};
        vt[9]  = '{2'd0, 1, 1, 25'h1001,  1,  1, 1'b0, 1'b0};
        vt[10] = '{2'd0, 1, 1, 25'h1001,  0,  0, 1'b0, 1'b0};
        vt[11] = '{2'd1, 1, 1, 25'h1001,  0,  0, 1'b0, 1'b0};
        vt[12] = '{2'd1, 3, 3, 25'h1001,  1,  0, 1'b0, 1'b0};
        vt[13] = '{2'd0, 4, 0, 25'h1001, 21, 21, 1'b0, 1'b0};
        vt[14] = '{2'd1, 3, 3, 25'h1001,  1,  0, 1'b0, 1'b0};
        vt[15] = '{2'd0, 3, 3, 25'h1001,  1,  1, 1'b0, 1'b1};
        vt[16] = '{2'd2, 0, 0, 25'h1001, 25, 25, 1'b0, 1'b0};
        vt[17] = '{2'd0, 0, 0, 25'h1001,  3, 26, 1'b1, 1'b0};
        vt[18] = '{2'd0, 1, 1, 25'h1001,  0,  0, 1'b1, 1'b0};
        vt[19] = '{2'd1, 1, 1, 25'h1001,  0,  0, 1'b1, 1'b0};
        vt[20] = '{2'd2, 0, 0, 25'h1001, 25, 25, 1'b0, 1'b0};

        // Reset values, then the power-up clear.
        bus.mine_map  = 25'h1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_x     = 3'd0;
        bus.cmd_y     = 3'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wEn", int'(bus.wEn), 0);
        check("rst_addr", int'(bus.addr), 0);
        check("rst_dataIn", int'(bus.dataIn), 0);
        check("rst_cmd_ready", int'(bus.cmd_ready), 0);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_game_over", int'(bus.game_over), 0);
        check("rst_game_won", int'(bus.game_won), 0);
        reset = 1'b1;
        model_clear(25'h1);
        observe(nw, bz);
        check("init_clear_writes", nw, 25);
        check("init_clear_busy", bz, 25);
        $display("[TB] reset clear writes=%0d busy=%0d", nw, bz);

        for (int i = 0; i < 21; i++) begin
            issue(vt[i].op, vt[i].x, vt[i].y, vt[i].map, nw, bz);
            check($sformatf("vec%0d_writes", i), nw, vt[i].nw);
            check($sformatf("vec%0d_busy", i), bz, vt[i].busy);
            check($sformatf("vec%0d_over", i), int'(bus.game_over), int'(vt[i].over));
            check($sformatf("vec%0d_won", i), int'(bus.game_won), int'(vt[i].won));
        end

        // Reset for one cycle in the middle of a flood fill, with an ignored clear pending on cmd_valid.
        issue(2'd2, 0, 0, 25'h1, nw, bz);
        model_cmd(2'd0, 4, 4, 25'h1);
        bus.cmd_op    = 2'd0;
        bus.cmd_x     = 3'd4;
        bus.cmd_y     = 3'd4;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.cmd_op    = 2'd2;
            bus.cmd_valid = 1'b1;
            check($sformatf("fill%0d_wEn", i), int'(bus.wEn), 1);
            check($sformatf("fill%0d_addr", i), int'(bus.addr), exp_q[i].a);
            check($sformatf("fill%0d_data", i), int'(bus.dataIn), exp_q[i].d);
            $display("[TB] fill cycle %0d addr=%0d data=%0d", i, bus.addr, bus.dataIn);
        end
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("abort_wEn", int'(bus.wEn), 0);
        check("abort_addr", int'(bus.addr), 0);
        check("abort_dataIn", int'(bus.dataIn), 0);
        check("abort_cmd_ready", int'(bus.cmd_ready), 0);
        check("abort_busy", int'(bus.busy), 1);
        reset = 1'b1;
        model_clear(25'h1);
        observe(nw, bz);
        check("abort_clear_writes", nw, 25);
        check("abort_clear_busy", bz, 25);
        check("abort_game_won", int'(bus.game_won), 0);
        $display("[TB] abort clear writes=%0d busy=%0d won=%0d", nw, bz, bus.game_won);

        // Randomized games against the model.
        for (int r = 0; r < 4; r++) begin
            logic [24:0] map = '0;
            for (int b = 0; b < 25; b++) map[b] = ($urandom_range(0, 5) == 0);
            issue(2'd2, 0, 0, map, nw, bz);
            for (int k = 0; k < 30; k++) begin
                int sel = int'($urandom_range(0, 9));
                logic [1:0] op = (sel < 6) ? 2'd0 : (sel < 9) ? 2'd1 : 2'd3;
                issue(op, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), map, nw, bz);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/board_reveal_engine.md
# board_reveal_engine

Game-logic writer for the 5x5 minesweeper board-status RAM that the VGA display path reads. It accepts cursor commands (reveal, flag toggle, clear board), computes neighbor-mine counts from a latched mine map, flood-fills zero-count regions, and writes one 4-bit status per cycle into the status RAM. It also reports win and loss.

## Interface
- Parameters: none. Board is fixed at 5x5. Cell id = 5*y + x, range 0..24.
- Status encoding (decided, matches display palette): 0..8 = revealed with n adjacent mines; 9 = mine shown; 10 = hidden; 11 = flagged.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `mine_map`  in  25  bit i = mine at cell i.
- `cmd_valid`  in  1  command request.
- `cmd_op`  in  2  operation: 0 = reveal, 1 = flag toggle, 2 = clear, 3 = reserved (treated as no-op).
- `cmd_x`  in  3  cursor column.
- `cmd_y`  in  3  cursor row.
- `cmd_ready`  out  1  engine can accept a command.
- `wEn`  out  1  status-RAM write enable.
- `addr`  out  12  status-RAM address: zero-extended cell id.
- `dataIn`  out  32  write data: {28'b0, status}.
- `busy`  out  1  equals ~cmd_ready.
- `game_over`  out  1  mine was revealed.
- `game_won`  out  1  all non-mine cells are revealed.

## Operation
- Internal state:
  - 25x4 shadow of the RAM contents.
  - 25-bit mine register.
  - 25-bit pending mask.
  - 5-bit revealed counter.
  - 5-bit scan index.
- States: CLEAR, IDLE, REVEAL, LOSE.
- Handshake:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_ready = 1 only in IDLE.
  - When game_over or game_won is set, only op 2 acts; any other accepted op is a no-op and causes no write.
- Out-of-range cursor (x>4 or y>4) on reveal or flag: the command is accepted and causes no write. It stays in IDLE.
- CLEAR:
  - Entered on reset and on an accepted op 2.
  - The mine register loads mine_map on every reset cycle and at the op-2 acceptance edge.
  - Clears game_over, game_won, the revealed counter and the pending mask.
  - Writes status 10 to cells 0..24 in index order, one per cycle, and updates the shadow to match.
  - Goes to IDLE after cell 24 is written.
- Reveal:
  - Target is flagged or already revealed: no-op, stays in IDLE.
  - Target is a mine: write 9 to the target, then go to LOSE.
  - Otherwise: set the pending bit of the target and go to REVEAL.
- REVEAL, each cycle:
  - Select c = lowest set pending bit. Write count(c) = popcount of the mine bits of its up to 8 in-board neighbors.
  - Clear pending[c], set shadow[c] = count, increment the revealed counter.
  - If count(c) == 0, OR into pending every in-board neighbor that is hidden (10), not flagged, not a mine and not already pending.
  - When pending is empty at an edge, go to IDLE.
  - At that edge, set game_won if revealed == 25 - popcount(mines).
- Flag toggle: hidden becomes 11, flagged becomes 10. One write. Revealed cells are a no-op.
- LOSE:
  - Scan index 0..24, one per cycle. wEn = 1 only where the mine bit is set (status 9).
  - After index 24, set game_over and go to IDLE.
- Reset mid-operation aborts any state. The engine restarts in CLEAR.

## Timing
- Values while reset is asserted:
  - state = CLEAR, index 0.
  - wEn = 0, addr = 0, dataIn = 0.
  - cmd_ready = 0, busy = 1.
  - game_over = 0, game_won = 0.
- Clearing after reset:
  - The first CLEAR write appears in the first cycle after reset deasserts.
  - 25 write cycles follow.
  - cmd_ready rises the cycle after the write to cell 24.
- Writes are registered outputs. The write is presented in the cycle after the acceptance edge (or after the previous write).
- Reveal of k cells: exactly k consecutive cycles with wEn = 1, and cmd_ready low for exactly k cycles.
- Flag toggle: 1 write cycle. A no-op command (including an out-of-range cursor): cmd_ready stays high, 0 busy cycles.
- Mine hit: 1 cycle writing the target, then 25 LOSE cycles. game_over rises with cmd_ready.
- game_won rises in the same cycle cmd_ready returns high.
- cmd_valid is ignored while cmd_ready = 0; no command is queued.

## Test plan
- Reset, mine_map = 25'h1:
  - 25 writes of status 10 to addresses 0..24.
  - cmd_ready = 1 at cycle 26.
- Reveal (4,4), same map:
  - 24 writes in lowest-index-first order.
  - Cells 1, 5 and 6 get status 1; the others get 0; cell 0 is never written.
  - game_won = 1 when cmd_ready returns high.
- mine_map bits {0,12}, reveal (0,0):
  - One write of 9 to address 0.
  - Then writes of 9 to addresses 0 and 12 during the LOSE scan.
  - game_over = 1 after 26 busy cycles.
  - A subsequent reveal is a no-op.
- Flag (2,2):
  - Write of 11 to address 12.
  - A reveal of (2,2) then produces no write.
  - A second flag writes 10 to address 12.
- Reveal (7,1):
  - Accepted with no write; cmd_ready stays 1.
- Reset asserted for 1 cycle in the middle of a flood fill:
  - Outputs take their reset values.
  - A full 25-cycle CLEAR follows.
  - game_won = 0.
